// File: rtl/div_arbiter_if.sv
// Handshake bundle between the arbiter (master) and one shared sequential divider (slave).
interface div_arbiter_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] dvnd;
  logic [W-1:0] dvsr;
  logic [W-1:0] quo;
  logic [W-1:0] rmd;
  logic         ready;
  logic         done_tick;

  modport master (output start, dvnd, dvsr, input quo, rmd, ready, done_tick);
  modport slave  (input start, dvnd, dvsr, output quo, rmd, ready, done_tick);
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider among N requesters; a zero
// divisor is answered locally without ever starting the divider.
module div_arbiter #(
  parameter int W   = 32,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] dvnd_bus,
  input  logic [N*W-1:0] dvsr_bus,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   res_quo,
  output logic [W-1:0]   res_rmd,
  output logic           res_err,
  output logic [IDW-1:0] res_id,
  output logic           busy,
  div_arbiter_if.master  div
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [W-1:0]   dvnd_q, dvnd_d;
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rmd_q, rmd_d;
  logic           err_q, err_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           start_q, start_d;
  logic           busy_q, busy_d;

  logic           found;
  logic [IDW-1:0] win;

  function automatic logic [IDW-1:0] wrap_id(input int unsigned v);
    return IDW'(v % N);
  endfunction

  // Rotating priority: the search starts at ptr and wraps around.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[wrap_id(32'(ptr_q) + k)]) begin
        found = 1'b1;
        win   = wrap_id(32'(ptr_q) + k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    res_id_d = res_id_q;
    dvnd_d   = dvnd_q;
    dvsr_d   = dvsr_q;
    quo_d    = quo_q;
    rmd_d    = rmd_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (found && div.ready) begin
          state_d  = ISSUE;
          res_id_d = win;
          dvnd_d   = dvnd_bus[32'(win)*W +: W];
          dvsr_d   = dvsr_bus[32'(win)*W +: W];
        end
      end
      ISSUE: begin
        if (dvsr_q == '0) begin
          state_d = DONE;
          quo_d   = '1;
          rmd_d   = dvnd_q;
          err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (div.done_tick) begin
          state_d = DONE;
          quo_d   = div.quo;
          rmd_d   = div.rmd;
          err_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = wrap_id(32'(res_id_q) + 1);
      end
    endcase
    // Start and ack are decoded one cycle early so both leave the block registered.
    start_d = (state_q == IDLE) && (state_d == ISSUE) && (dvsr_d != '0);
    ack_d   = (state_d == DONE) ? (N'(1) << res_id_d) : '0;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      res_id_q <= '0;
      dvnd_q   <= '0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      rmd_q    <= '0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      res_id_q <= res_id_d;
      dvnd_q   <= dvnd_d;
      dvsr_q   <= dvsr_d;
      quo_q    <= quo_d;
      rmd_q    <= rmd_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign res_quo   = quo_q;
  assign res_rmd   = rmd_q;
  assign res_err   = err_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;
  assign div.start = start_q;
  assign div.dvnd  = dvnd_q;
  assign div.dvsr  = dvsr_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, transaction-level reference model,
// directed scenarios plus randomized multi-requester traffic.
module tb_div_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] dvnd_bus;
  logic [N*W-1:0] dvsr_bus;
  logic [N-1:0]   ack;
  logic [W-1:0]   res_quo;
  logic [W-1:0]   res_rmd;
  logic           res_err;
  logic [IDW-1:0] res_id;
  logic           busy;

  div_arbiter_if #(.W(W)) dif ();

  div_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .dvnd_bus(dvnd_bus), .dvsr_bus(dvsr_bus),
    .ack(ack), .res_quo(res_quo), .res_rmd(res_rmd), .res_err(res_err), .res_id(res_id),
    .busy(busy), .div(dif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cnt = 0;

  // divider model state
  int         d_cnt   = 0;
  int         d_fixed = 3;
  logic       hold_nr = 1'b0;
  logic [W-1:0] d_a, d_b;

  logic [N-1:0] cool;

  // reference model: one operation in flight, described by its grant and done edges
  logic       m_active;
  int         m_gedge, m_done_edge, m_id, m_ptr, m_res_id;
  logic [W-1:0] m_a, m_b, m_quo, m_rmd;
  logic       m_err;
  int         grant_log[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_gedge = -10; m_done_edge = -10; m_id = 0; m_ptr = 0; m_res_id = 0;
    m_a = '0; m_b = '0; m_quo = '0; m_rmd = '0; m_err = 1'b0;
  endtask

  // Advance the model by the rising edge that just passed, using the inputs it sampled.
  task automatic model_edge();
    if (!m_active) begin
      if (dif.ready) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (req[i] && !m_active) begin
            m_active = 1'b1; m_gedge = cyc; m_id = i; m_res_id = i;
            m_a = dvnd_bus[i*W +: W]; m_b = dvsr_bus[i*W +: W];
            m_done_edge = (m_b == '0) ? cyc + 1 : -10;
            grant_log.push_back(i);
          end
        end
      end
    end else begin
      if (m_done_edge < 0 && cyc >= m_gedge + 2 && dif.done_tick) begin
        m_done_edge = cyc; m_quo = dif.quo; m_rmd = dif.rmd; m_err = 1'b0;
      end
      if (cyc == m_done_edge) begin
        if (m_b == '0) begin m_quo = '1; m_rmd = m_a; m_err = 1'b1; end
        m_ptr = (m_id + 1) % N;
      end else if (m_done_edge >= 0 && cyc == m_done_edge + 1) begin
        m_active = 1'b0;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_ack;
    logic         e_start;
    e_ack   = (m_active && cyc == m_done_edge) ? (N'(1) << m_id) : '0;
    e_start = m_active && (cyc == m_gedge) && (m_b != '0);
    chk("busy",     32'(busy),      32'(m_active));
    chk("ack",      32'(ack),       32'(e_ack));
    chk("start",    32'(dif.start), 32'(e_start));
    chk("res_quo",  res_quo,        m_quo);
    chk("res_rmd",  res_rmd,        m_rmd);
    chk("res_err",  32'(res_err),   32'(m_err));
    chk("res_id",   32'(res_id),    32'(m_res_id));
    chk("div_dvnd", dif.dvnd,       m_a);
    chk("div_dvsr", dif.dvsr,       m_b);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (reset_n) model_edge(); else model_reset();
    compare();
    if (dif.start === 1'b1) start_cnt++;
    for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
    cool = ack;
    // divider: done_tick D negedges after the start is seen
    dif.done_tick = 1'b0;
    if (d_cnt > 0) begin
      d_cnt--;
      if (d_cnt == 0) begin
        dif.done_tick = 1'b1;
        dif.quo = (d_b == '0) ? '1  : d_a / d_b;
        dif.rmd = (d_b == '0) ? d_a : d_a % d_b;
      end
    end else if (dif.start === 1'b1) begin
      d_cnt = (d_fixed > 0) ? d_fixed : int'($urandom_range(1, 5));
      d_a = dif.dvnd; d_b = dif.dvsr;
    end
    dif.ready = (d_cnt == 0) && !hold_nr;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    dvnd_bus[i*W +: W] = a;
    dvsr_bus[i*W +: W] = b;
  endtask

  // lat counts the cycle the request is presented through the ack cycle inclusive
  task automatic wait_ack(input string nm, input int budget, output int lat, output logic ok);
    lat = 1; ok = 1'b0;
    while (lat <= budget && !ok) begin
      step();
      lat++;
      if (ack != '0) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s: no ack within %0d cycles", nm, budget); end
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (busy && k < 80) begin step(); k++; end
    step();
    n_tests++;
    if (busy) begin n_fail++; $display("FAIL %s: busy still 1, expected 0 after drain", nm); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, s0;
    logic ok;
    int got[$];
    int exp_order[6];
    logic [W-1:0] fa[N], fb[N];
    exp_order = '{0, 1, 2, 3, 0, 1};

    reset_n = 1'b0; req = '0; dvnd_bus = '0; dvsr_bus = '0; cool = '0;
    dif.ready = 1'b1; dif.done_tick = 1'b0; dif.quo = '0; dif.rmd = '0;
    model_reset();
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // single request, D = 5
    d_fixed = 5; s0 = start_cnt;
    set_op(0, 100, 7); req = 4'b0001;
    wait_ack("single", 40, lat, ok);
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_lat", 32'(lat), 32'd8);
    chk("single_quo", res_quo, 32'd14);
    chk("single_rmd", res_rmd, 32'd2);
    chk("single_err", 32'(res_err), 32'h0);
    chk("single_id", 32'(res_id), 32'h0);
    chk("model_quo", m_quo, 32'd14);
    chk("single_starts", 32'(start_cnt - s0), 32'd1);
    drain("single");

    // zero divisor on port 2
    s0 = start_cnt;
    set_op(2, 32'h1234, 0); req = 4'b0100;
    wait_ack("zero", 20, lat, ok);
    chk("zero_ack", 32'(ack), 32'h4);
    chk("zero_lat", 32'(lat), 32'd3);
    chk("zero_quo", res_quo, 32'hFFFF_FFFF);
    chk("zero_rmd", res_rmd, 32'h1234);
    chk("zero_err", 32'(res_err), 32'h1);
    chk("zero_starts", 32'(start_cnt - s0), 32'd0);
    drain("zero");

    // port 3 op moves the pointer back to 0
    d_fixed = 2;
    set_op(3, 500, 8); req = 4'b1000;
    wait_ack("port3", 30, lat, ok);
    chk("port3_quo", res_quo, 32'd62);
    chk("port3_rmd", res_rmd, 32'd4);
    drain("port3");

    // fairness with all ports requesting and re-raising after each ack
    d_fixed = 0;
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      fa[i] = 32'(1000 + i * 37); fb[i] = 32'(i + 3);
      set_op(i, fa[i], fb[i]);
    end
    req = '1;
    for (int t = 0; t < 400 && got.size() < 6; t++) begin
      step();
      if (ack != '0) begin
        got.push_back(int'(res_id));
        chk("fair_quo", res_quo, fa[res_id] / fb[res_id]);
        chk("fair_rmd", res_rmd, fa[res_id] % fb[res_id]);
      end
      for (int i = 0; i < N; i++) if (!req[i] && !cool[i]) req[i] = 1'b1;
    end
    req = '0;
    chk("fair_count", 32'(got.size()), 32'd6);
    for (int k = 0; k < got.size() && k < 6; k++) begin
      chk("fair_order", 32'(got[k]), 32'(exp_order[k]));
      chk("model_order", 32'(grant_log[k]), 32'(exp_order[k]));
    end
    drain("fair");

    // divider not ready: no grant until ready is seen
    d_fixed = 3;
    hold_nr = 1'b1; dif.ready = 1'b0;
    set_op(1, 81, 9); req = 4'b0010;
    for (int t = 0; t < 10; t++) begin
      step();
      chk("nr_busy", 32'(busy), 32'h0);
    end
    hold_nr = 1'b0; dif.ready = 1'b1;
    step();
    chk("nr_grant_busy", 32'(busy), 32'h1);
    chk("nr_grant_id", 32'(res_id), 32'h1);
    wait_ack("notready", 30, lat, ok);
    chk("nr_quo", res_quo, 32'd9);
    chk("nr_rmd", res_rmd, 32'd0);
    drain("notready");

    // operands change and req drops after grant
    d_fixed = 6;
    set_op(3, 5000, 9); req = 4'b1000;
    step();
    step();
    set_op(3, 77, 0); req = 4'b0000;
    wait_ack("late_change", 30, lat, ok);
    chk("late_ack", 32'(ack), 32'h8);
    chk("late_quo", res_quo, 32'd555);
    chk("late_rmd", res_rmd, 32'd5);
    chk("late_err", 32'(res_err), 32'h0);
    drain("late_change");

    // asynchronous reset while waiting for the divider
    d_fixed = 8;
    set_op(1, 300, 7); req = 4'b0010;
    repeat (4) step();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_start", 32'(dif.start), 32'h0);
    chk("rst_quo", res_quo, 32'h0);
    chk("rst_rmd", res_rmd, 32'h0);
    chk("rst_err", 32'(res_err), 32'h0);
    chk("rst_id", 32'(res_id), 32'h0);
    chk("rst_dvnd", dif.dvnd, 32'h0);
    chk("rst_dvsr", dif.dvsr, 32'h0);
    model_reset();
    req = '0;
    repeat (2) step();
    reset_n = 1'b1;
    d_fixed = 3; s0 = start_cnt;
    set_op(2, 90, 4); req = 4'b0100;
    wait_ack("after_reset", 40, lat, ok);
    chk("ar_ack", 32'(ack), 32'h4);
    chk("ar_quo", res_quo, 32'd22);
    chk("ar_rmd", res_rmd, 32'd2);
    chk("ar_starts", 32'(start_cnt - s0), 32'd1);
    drain("after_reset");

    // randomized traffic from all ports
    d_fixed = 0;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !cool[i] && $urandom_range(0, 5) == 0) begin
          logic [W-1:0] a, b;
          int r;
          r = int'($urandom_range(0, 7));
          a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 5000));
          if (r == 0)      b = '0;
          else if (r <= 2) b = $urandom;
          else             b = 32'($urandom_range(1, 300));
          set_op(i, a, b);
          req[i] = 1'b1;
        end
      end
      hold_nr = ($urandom_range(0, 9) == 0);
      step();
    end
    req = '0; hold_nr = 1'b0;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
